// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared encodings for the pipeline run-control sequencer.
//   state_e      - 3-bit FSM state codes exported on run_controller.state
//   stop_cause_e - 2-bit reason the pipeline last stopped
//   DRAIN_CYCLES_DEF - default ID->WB drain depth after a halt opcode
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_USER = 2'd1,
    CAUSE_BP   = 2'd2,
    CAUSE_END  = 2'd3
  } stop_cause_e;

  localparam int unsigned DRAIN_CYCLES_DEF = 4;

endpackage

// File: rtl/run_controller.sv
// run_controller: run-control sequencer for the 5-stage pipeline.
// Generates the single pipeline clock-enable (pipe_en) and supports free-run,
// single-step, user halt, PC breakpoint and drain-on-halt-opcode.
// Ports:
//   clock, reset      - clock; asynchronous active-high reset
//   run_req/step_req/halt_req - single-cycle request pulses from the UI logic
//   bp_enable, bp_addr - breakpoint arm and address
//   pc                 - current fetch PC
//   halt_instr         - ID stage holds the halt opcode
//   pipe_en            - pipeline clock-enable (combinational)
//   state, stop_cause, halted - status for the UI handler
//   cycles_run         - saturating count of enabled cycles
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int unsigned PC_WIDTH     = 16,
  parameter int unsigned CNT_WIDTH    = 16,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 run_req,
  input  logic                 step_req,
  input  logic                 halt_req,
  input  logic                 bp_enable,
  input  logic [PC_WIDTH-1:0]  bp_addr,
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic                 halt_instr,
  output logic                 pipe_en,
  output logic [2:0]           state,
  output logic [1:0]           stop_cause,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] cycles_run
);

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_e         r_state, w_state_nxt;
  stop_cause_e    r_stop_cause, w_stop_nxt;
  logic           r_halted, w_halted_nxt;
  logic           r_resume, w_resume_nxt;
  logic [DW-1:0]  r_drain_cnt, w_drain_nxt;
  logic [CNT_WIDTH-1:0] r_cycles;
  logic           w_bp_hit;
  logic           w_pipe_en;

  // resume masks the breakpoint for the first RUN cycle so a run started
  // while parked on the breakpoint PC can step past it.
  assign w_bp_hit = bp_enable && (pc == bp_addr) && !r_resume;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_stop_cause <= CAUSE_NONE;
      r_halted     <= 1'b0;
      r_resume     <= 1'b0;
      r_drain_cnt  <= '0;
      r_cycles     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_stop_cause <= w_stop_nxt;
      r_halted     <= w_halted_nxt;
      r_resume     <= w_resume_nxt;
      r_drain_cnt  <= w_drain_nxt;
      if (w_pipe_en && (r_cycles != '1)) begin
        r_cycles <= r_cycles + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_stop_nxt   = r_stop_cause;
    w_halted_nxt = r_halted;
    w_resume_nxt = r_resume;
    w_drain_nxt  = r_drain_cnt;
    w_pipe_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (run_req) begin
          w_state_nxt  = ST_RUN;
          w_resume_nxt = 1'b1;
          w_stop_nxt   = CAUSE_NONE;
        end else if (step_req) begin
          w_state_nxt = ST_STEP;
        end
      end
      ST_RUN: begin
        // A user halt coinciding with a breakpoint takes priority, so the
        // cycle stays enabled and the stop is reported as a user halt.
        w_pipe_en    = !w_bp_hit || halt_req;
        w_resume_nxt = 1'b0;
        if (halt_instr && w_pipe_en) begin
          w_state_nxt = ST_DRAIN;
          w_drain_nxt = DW'(DRAIN_CYCLES - 1);
        end else if (halt_req) begin
          w_state_nxt = ST_IDLE;
          w_stop_nxt  = CAUSE_USER;
        end else if (w_bp_hit) begin
          w_state_nxt = ST_IDLE;
          w_stop_nxt  = CAUSE_BP;
        end
      end
      ST_STEP: begin
        w_pipe_en = 1'b1;
        if (halt_instr) begin
          w_state_nxt = ST_DRAIN;
          w_drain_nxt = DW'(DRAIN_CYCLES - 1);
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        w_pipe_en = 1'b1;
        if (r_drain_cnt == '0) begin
          w_state_nxt  = ST_HALTED;
          w_stop_nxt   = CAUSE_END;
          w_halted_nxt = 1'b1;
        end else begin
          w_drain_nxt = r_drain_cnt - DW'(1);
        end
      end
      ST_HALTED: begin
        w_pipe_en = 1'b0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign pipe_en    = w_pipe_en;
  assign state      = r_state;
  assign stop_cause = r_stop_cause;
  assign halted     = r_halted;
  assign cycles_run = r_cycles;

endmodule
